// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the five-stage pipeline datapath and hazard_ctrl.
// The slave side is the hazard controller; the master side is the pipeline.
interface hazard_ctrl_if #(
  parameter int RWIDTH = 5,
  parameter int CWIDTH = 16
);
  logic              d_valid_i;
  logic [RWIDTH-1:0] d_rs1_i;
  logic [RWIDTH-1:0] d_rs2_i;
  logic              d_uses_rs1_i;
  logic              d_uses_rs2_i;
  logic [RWIDTH-1:0] d_rd_i;
  logic              d_regwren_i;
  logic              d_memren_i;
  logic              d_memwren_i;
  logic              e_br_taken_i;
  logic              dmem_ready_i;

  logic              f_stall_o;
  logic              d_stall_o;
  logic              d_flush_o;
  logic              e_bubble_o;
  logic              m_stall_o;
  logic [1:0]        fwd_a_o;
  logic [1:0]        fwd_b_o;
  logic              e_valid_o;
  logic              m_valid_o;
  logic              w_valid_o;
  logic [CWIDTH-1:0] stall_cnt_o;
  logic [CWIDTH-1:0] flush_cnt_o;

  modport slave (
    input  d_valid_i, d_rs1_i, d_rs2_i, d_uses_rs1_i, d_uses_rs2_i, d_rd_i,
           d_regwren_i, d_memren_i, d_memwren_i, e_br_taken_i, dmem_ready_i,
    output f_stall_o, d_stall_o, d_flush_o, e_bubble_o, m_stall_o,
           fwd_a_o, fwd_b_o, e_valid_o, m_valid_o, w_valid_o,
           stall_cnt_o, flush_cnt_o
  );

  modport master (
    output d_valid_i, d_rs1_i, d_rs2_i, d_uses_rs1_i, d_uses_rs2_i, d_rd_i,
           d_regwren_i, d_memren_i, d_memwren_i, e_br_taken_i, dmem_ready_i,
    input  f_stall_o, d_stall_o, d_flush_o, e_bubble_o, m_stall_o,
           fwd_a_o, fwd_b_o, e_valid_o, m_valid_o, w_valid_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the F/D/E/M/W pipeline: tracks in-flight register tags,
// produces forwarding selects, load-use/memory-wait stalls and branch flushes.
module hazard_ctrl #(
  parameter int RWIDTH = 5,
  parameter int CWIDTH = 16,
  parameter bit FWD_WB = 1'b1
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave hz
);

  typedef struct packed {
    logic              valid;
    logic [RWIDTH-1:0] rs1;
    logic [RWIDTH-1:0] rs2;
    logic              uses1;
    logic              uses2;
    logic [RWIDTH-1:0] rd;
    logic              regwren;
    logic              memren;
    logic              memwren;
  } e_shadow_t;

  typedef struct packed {
    logic              valid;
    logic [RWIDTH-1:0] rd;
    logic              regwren;
    logic              memren;
    logic              memwren;
  } mw_shadow_t;

  e_shadow_t         e_q, e_d;
  mw_shadow_t        m_q, m_d, w_q, w_d;
  logic [CWIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CWIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_wait, branch, load_use, d_hits_e, f_stall;
  logic w_unused;

  // Memory wait outranks the branch, which outranks load-use.
  assign mem_wait = m_q.valid & (m_q.memren | m_q.memwren) & ~hz.dmem_ready_i;
  assign branch   = e_q.valid & hz.e_br_taken_i & ~mem_wait;
  assign d_hits_e = (hz.d_uses_rs1_i & (hz.d_rs1_i == e_q.rd)) |
                    (hz.d_uses_rs2_i & (hz.d_rs2_i == e_q.rd));
  assign load_use = e_q.valid & e_q.memren & (e_q.rd != '0) & hz.d_valid_i &
                    d_hits_e & ~mem_wait & ~branch;
  assign f_stall  = mem_wait | load_use;

  // A load in M never forwards: the load-use bubble always puts it in W first.
  function automatic logic [1:0] fwd_sel(input logic e_valid, input logic uses,
                                         input logic [RWIDTH-1:0] rs,
                                         input mw_shadow_t m, input mw_shadow_t w);
    fwd_sel = 2'b00;
    if (e_valid && uses && rs != '0) begin
      if (m.valid && m.regwren && !m.memren && m.rd == rs)
        fwd_sel = 2'b01;
      else if (FWD_WB && w.valid && w.regwren && w.rd == rs)
        fwd_sel = 2'b10;
    end
  endfunction

  assign hz.f_stall_o   = f_stall;
  assign hz.d_stall_o   = f_stall;
  assign hz.d_flush_o   = branch;
  assign hz.e_bubble_o  = branch | load_use;
  assign hz.m_stall_o   = mem_wait;
  assign hz.fwd_a_o     = fwd_sel(e_q.valid, e_q.uses1, e_q.rs1, m_q, w_q);
  assign hz.fwd_b_o     = fwd_sel(e_q.valid, e_q.uses2, e_q.rs2, m_q, w_q);
  assign hz.e_valid_o   = e_q.valid;
  assign hz.m_valid_o   = m_q.valid;
  assign hz.w_valid_o   = w_q.valid;
  assign hz.stall_cnt_o = stall_cnt_q;
  assign hz.flush_cnt_o = flush_cnt_q;

  // W memory-access flags are tracked for completeness but drive no decision.
  assign w_unused = w_q.memren ^ w_q.memwren;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
    e_d         = e_q;
    m_d         = m_q;
    w_d         = w_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (mem_wait) begin
      w_d = '0;
    end else begin
      w_d         = m_q;
      m_d.valid   = e_q.valid;
      m_d.rd      = e_q.rd;
      m_d.regwren = e_q.regwren;
      m_d.memren  = e_q.memren;
      m_d.memwren = e_q.memwren;
      if (branch || load_use) begin
        e_d = '0;
      end else begin
        e_d.valid   = hz.d_valid_i;
        e_d.rs1     = hz.d_rs1_i;
        e_d.rs2     = hz.d_rs2_i;
        e_d.uses1   = hz.d_uses_rs1_i;
        e_d.uses2   = hz.d_uses_rs2_i;
        e_d.rd      = hz.d_rd_i;
        e_d.regwren = hz.d_regwren_i;
        e_d.memren  = hz.d_memren_i;
        e_d.memwren = hz.d_memwren_i;
      end
    end

    if (f_stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    if (branch && flush_cnt_q != '1)  flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
